// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 keystream consumer.
// Configuration macro: RC4_DISCARD_EN enables the RC4-drop[N] discard phase.
package rc4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DISCARD = 2'd1,
    ST_RUN     = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  typedef logic [7:0] byte_t;

  localparam int RC4_DISCARD_DEFAULT = 256;

  function automatic byte_t xor_byte(input byte_t a, input byte_t b);
    return a ^ b;
  endfunction

endpackage

// File: rtl/rc4_ks_fifo.sv
// Synchronous keystream FIFO; depth must be a power of two so pointers wrap naturally.
// Flush empties the FIFO and takes priority over a push or pop in the same cycle.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int KS_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  byte_t                     push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(KS_DEPTH):0] level,
  output byte_t                     head
);

  localparam int AW = $clog2(KS_DEPTH);
  localparam int LW = AW + 1;

  byte_t          mem [KS_DEPTH];
  logic  [AW-1:0] rd_ptr;
  logic  [AW-1:0] wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (level == LW'(KS_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset: head is only consumed when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rc4_xor_stream.sv
// XORs buffered RC4 keystream bytes with plaintext into a registered ciphertext stream.
// Configuration macro: RC4_DISCARD_EN adds the DISCARD state that drops DISCARD_N bytes after reset/rekey.
module rc4_xor_stream
  import rc4_pkg::*;
#(
  parameter int KS_DEPTH  = 4,
  parameter int LEN_W     = 16,
  parameter int DISCARD_N = RC4_DISCARD_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [LEN_W-1:0]          msg_len,
  input  logic                      rekey,
  input  logic                      ks_valid,
  input  logic [7:0]                ks_data,
  output logic                      ks_ready,
  input  logic                      pt_valid,
  input  logic [7:0]                pt_data,
  output logic                      pt_ready,
  output logic                      ct_valid,
  output logic [7:0]                ct_data,
  input  logic                      ct_ready,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(KS_DEPTH):0] ks_level,
  output state_t                    dbg_state
);

  if ((KS_DEPTH < 2) || ((KS_DEPTH & (KS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("KS_DEPTH must be a power of two and at least 2");
  end
  if (DISCARD_N < 1) begin : g_bad_discard
    $error("DISCARD_N must be at least 1");
  end

  // All three byte streams: a transfer happens in a cycle where valid and ready
  // are both high; a producer holds valid and data stable until that cycle.
  state_t           state;
  logic [LEN_W-1:0] remain;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  byte_t            fifo_head;
  logic             fire;
  logic             start_ok;
  logic             disc_needed;
  logic             disc_last;

  assign ks_ready  = !fifo_full;
  assign start_ok  = (state == ST_IDLE) && start && !busy;
  assign fire      = (state == ST_RUN) && pt_valid && !fifo_empty && (!ct_valid || ct_ready);
  assign pt_ready  = fire;
  assign dbg_state = state;

`ifdef RC4_DISCARD_EN
  localparam int DW = $clog2(DISCARD_N + 1);

  logic [DW-1:0] disc_cnt;
  logic          disc_pending;
  logic          disc_pop;

  assign disc_pop    = (state == ST_DISCARD) && !fifo_empty;
  assign disc_last   = disc_pop && !rekey && (disc_cnt == DW'(DISCARD_N - 1));
  assign disc_needed = disc_pending;
  assign fifo_pop    = fire || disc_pop;

  // A rekey mid-discard restarts the count, since the flushed bytes never got dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      disc_pending <= 1'b1;
      disc_cnt     <= '0;
    end else if (rekey) begin
      disc_pending <= 1'b1;
      disc_cnt     <= '0;
    end else if (disc_last) begin
      disc_pending <= 1'b0;
      disc_cnt     <= '0;
    end else if (disc_pop) begin
      disc_cnt     <= disc_cnt + 1'b1;
    end
  end
`else
  assign disc_last   = 1'b0;
  assign disc_needed = 1'b0;
  assign fifo_pop    = fire;
`endif

  rc4_ks_fifo #(
    .KS_DEPTH (KS_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ks_valid),
    .push_data (ks_data),
    .pop       (fifo_pop),
    .flush     (rekey),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (ks_level),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      remain   <= '0;
      ct_valid <= 1'b0;
      ct_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // busy stays high through the done cycle, then drops.
      if (done) busy <= 1'b0;

      if (fire) begin
        ct_valid <= 1'b1;
        ct_data  <= xor_byte(pt_data, fifo_head);
      end else if (ct_ready) begin
        ct_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            busy <= 1'b1;
            if (msg_len == '0) begin
              done <= 1'b1;
            end else begin
              remain <= msg_len;
              state  <= disc_needed ? ST_DISCARD : ST_RUN;
            end
          end
        end
        ST_DISCARD: begin
          if (disc_last) state <= ST_RUN;
        end
        ST_RUN: begin
          if (fire) begin
            remain <= remain - 1'b1;
            if (remain == LEN_W'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (ct_valid && ct_ready) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Bench for rc4_xor_stream: directed steps plus randomized messages against a byte-stream model.
// Build with RC4_DISCARD_EN defined to exercise the drop-N discard with DISCARD_N=4.
module tb_rc4_xor_stream;
  import rc4_pkg::*;

  localparam int KS_DEPTH = 4;
  localparam int LEN_W    = 16;
`ifdef RC4_DISCARD_EN
  localparam int DISCARD_N = 4;
`else
  localparam int DISCARD_N = RC4_DISCARD_DEFAULT;
`endif
  localparam int LVL_W = $clog2(KS_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] msg_len;
  logic             rekey;
  logic             ks_valid;
  logic [7:0]       ks_data;
  logic             ks_ready;
  logic             pt_valid;
  logic [7:0]       pt_data;
  logic             pt_ready;
  logic             ct_valid;
  logic [7:0]       ct_data;
  logic             ct_ready;
  logic             busy;
  logic             done;
  logic [LVL_W-1:0] ks_level;
  state_t           dbg_state;

  rc4_xor_stream #(
    .KS_DEPTH  (KS_DEPTH),
    .LEN_W     (LEN_W),
    .DISCARD_N (DISCARD_N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .msg_len   (msg_len),
    .rekey     (rekey),
    .ks_valid  (ks_valid),
    .ks_data   (ks_data),
    .ks_ready  (ks_ready),
    .pt_valid  (pt_valid),
    .pt_data   (pt_data),
    .pt_ready  (pt_ready),
    .ct_valid  (ct_valid),
    .ct_data   (ct_data),
    .ct_ready  (ct_ready),
    .busy      (busy),
    .done      (done),
    .ks_level  (ks_level),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard and model state ----------------
  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];   // expected ciphertext bytes, in order
  logic [7:0] ks_m[$];    // keystream bytes held by the FIFO, in order
  logic [7:0] ks_src[$];  // keystream bytes still to be offered
  logic [7:0] pt_src[$];  // plaintext bytes still to be offered
  logic [7:0] ct_log[$];
  int         ct_cyc[$];

  bit         busy_e, done_e, ctv_e, pend_e, prev_stall;
  logic [7:0] prev_ct;
  int         fire_left, ct_left, drop_left;
  int         ks_pct = 100, pt_pct = 100, ct_pct = 100, ct_stall = 0;
  bit         ks_hold, pt_hold;
  int         cyc = 0, done_cnt = 0, done_cyc = 0, pt_hs_cnt = 0, ct_hs_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ks_m.delete();
    exp_q.delete();
    busy_e = 0; done_e = 0; ctv_e = 0; pend_e = 1; prev_stall = 0;
    fire_left = 0; ct_left = 0; drop_left = 0;
    ks_hold = 0; pt_hold = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    ks_valid = (ks_src.size() > 0) && (ks_hold || ($urandom_range(99) < ks_pct));
    ks_data  = (ks_src.size() > 0) ? ks_src[0] : 8'h00;
    pt_valid = (pt_src.size() > 0) && (pt_hold || ($urandom_range(99) < pt_pct));
    pt_data  = (pt_src.size() > 0) ? pt_src[0] : 8'h00;
    if (ct_stall > 0) begin
      ct_ready = 1'b0;
      ct_stall--;
    end else begin
      ct_ready = ($urandom_range(99) < ct_pct);
    end
  endtask

  // Samples mid-cycle, checks against the model, advances the model, then steps to posedge+1.
  task automatic cycle();
    bit fire_e, disc_e, ct_hs, ks_hs, busy_n, done_n;
    int sz;
    #4;
    if (rst) begin
      model_reset();
    end else begin
      sz     = ks_m.size();
      disc_e = busy_e && (drop_left > 0);
      fire_e = busy_e && !disc_e && (fire_left > 0) && pt_valid && (sz > 0) && (!ctv_e || ct_ready);
      ct_hs  = ctv_e && ct_ready;
      ks_hs  = ks_valid && (sz < KS_DEPTH);

      check("pt_ready", pt_ready, fire_e);
      check("ks_ready", ks_ready, (sz < KS_DEPTH));
      check("ks_level", ks_level, sz);
      check("busy", busy, busy_e);
      check("done", done, done_e);
      check("ct_valid", ct_valid, ctv_e);
      if (prev_stall) check("ct_hold", ct_data, prev_ct);
      if (ct_hs && exp_q.size() > 0) begin
        check("ct_data", ct_data, exp_q.pop_front());
        ct_log.push_back(ct_data);
        ct_cyc.push_back(cyc);
        ct_hs_cnt++;
        ct_left--;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end

      done_n = 0;
      busy_n = done_e ? 1'b0 : busy_e;
      if (fire_e) begin
        exp_q.push_back(pt_data ^ ks_m.pop_front());
        fire_left--;
        pt_hs_cnt++;
      end
      if (disc_e && sz > 0) begin
        void'(ks_m.pop_front());
        drop_left--;
      end
      if (ks_hs) ks_m.push_back(ks_data);
      if (rekey) begin
        ks_m.delete();
        pend_e = 1;
      end
      if (ct_hs && ct_left == 0) done_n = 1;
      if (start && !busy_e) begin
        busy_n = 1;
        if (msg_len == '0) begin
          done_n = 1;
        end else begin
          fire_left = int'(msg_len);
          ct_left   = int'(msg_len);
`ifdef RC4_DISCARD_EN
          if (pend_e) begin
            drop_left = DISCARD_N;
            pend_e    = 0;
          end
`endif
        end
      end
      prev_stall = ctv_e && !ct_ready;
      prev_ct    = ct_data;
      ctv_e      = fire_e ? 1'b1 : (ct_hs ? 1'b0 : ctv_e);
      busy_e     = busy_n;
      done_e     = done_n;

      if (ks_hs) void'(ks_src.pop_front());
      ks_hold = ks_valid && !ks_hs;
      if (fire_e) void'(pt_src.pop_front());
      pt_hold = pt_valid && !fire_e;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      cycle();
    end
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    msg_len = LEN_W'(len);
    drive();
    cycle();
    start   = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      drive();
      cycle();
      n++;
    end
    check(tag, (done_cnt != d0), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    ks_src.delete();
    pt_src.delete();
  endtask

  task automatic check_reset_values(input string tag);
    drive();
    #1;
    check({tag, "_ks_ready"}, ks_ready, 1);
    check({tag, "_pt_ready"}, pt_ready, 0);
    check({tag, "_ct_valid"}, ct_valid, 0);
    check({tag, "_ct_data"}, ct_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ks_level"}, ks_level, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    int base;
    int d0;
    int p0;
    int len;
    int need;
    rst = 1'b1; start = 1'b0; msg_len = '0; rekey = 1'b0;
    ks_valid = 1'b0; ks_data = '0; pt_valid = 1'b0; pt_data = '0; ct_ready = 1'b1;
    model_reset();

    do_reset();
    check_reset_values("reset");

`ifndef RC4_DISCARD_EN
    // Prefetched keystream, full-rate message.
    ks_src = '{8'h10, 8'h20, 8'h30};
    idle(3);
    check("prefetch_level", ks_level, 3);
    pt_src = '{8'h41, 8'h42, 8'h43};
    base = ct_log.size();
    do_start(3);
    run_until_done("t1_done", 20);
    check("t1_ct0", ct_log[base], 8'h51);
    check("t1_ct1", ct_log[base+1], 8'h62);
    check("t1_ct2", ct_log[base+2], 8'h73);
    check("t1_consecutive", ct_cyc[base+2] - ct_cyc[base], 2);
    check("t1_done_latency", done_cyc - ct_cyc[base+2], 1);

    // Backpressure on byte 2.
    ks_src = '{8'h10, 8'h20, 8'h30};
    pt_src = '{8'h41, 8'h42, 8'h43};
    base = ct_log.size();
    do_start(3);
    while (ct_hs_cnt < base + 1 && cyc < 10000) idle(1);
    ct_stall = 3;
    for (int i = 0; i < 3; i++) begin
      drive();
      #1;
      check("t2_held_data", ct_data, 8'h62);
      check("t2_held_valid", ct_valid, 1);
      check("t2_pt_blocked", pt_ready, 0);
      cycle();
    end
    run_until_done("t2_done", 20);
    check("t2_ct1", ct_log[base+1], 8'h62);
    check("t2_ct2", ct_log[base+2], 8'h73);

    // Keystream starvation.
    pt_src = '{8'h5a};
    do_start(1);
    for (int i = 0; i < 3; i++) begin
      drive();
      #1;
      check("t3_starved", pt_ready, 0);
      cycle();
    end
    ks_src = '{8'ha5};
    idle(1);
    drive();
    #1;
    check("t3_fire", pt_ready, 1);
    cycle();
    drive();
    #1;
    check("t3_ct_valid", ct_valid, 1);
    check("t3_ct_data", ct_data, 8'hff);
    cycle();
    run_until_done("t3_done", 10);

    // FIFO full, then push and pop in the same cycle.
    ks_src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    idle(5);
    check("t4_full_ready", ks_ready, 0);
    check("t4_full_level", ks_level, 4);
    pt_src = '{8'h00, 8'h00};
    do_start(2);
    idle(1);
    check("t4_pop_level", ks_level, 3);
    idle(1);
    check("t4_pushpop_level", ks_level, 3);
    run_until_done("t4_done", 10);

    // Zero-length message.
    p0 = pt_hs_cnt;
    do_start(0);
    drive();
    #1;
    check("t5_done", done, 1);
    check("t5_busy", busy, 1);
    cycle();
    idle(1);
    check("t5_no_handshake", pt_hs_cnt - p0, 0);

    // start during RUN is ignored; uses leftover keystream 3,4,5.
    pt_src = '{8'h11, 8'h22, 8'h33, 8'h44};
    base = ct_log.size();
    p0 = pt_hs_cnt;
    do_start(3);
    idle(1);
    start = 1'b1; msg_len = LEN_W'(7);
    drive();
    cycle();
    start = 1'b0;
    run_until_done("t6_done", 20);
    check("t6_bytes", pt_hs_cnt - p0, 3);
    check("t6_ct2", ct_log[base+2], 8'h36);
    pt_src.delete();

    // rekey flushes the FIFO.
    ks_src = '{8'h09, 8'h09, 8'h09};
    idle(3);
    rekey = 1'b1;
    idle(1);
    rekey = 1'b0;
    check("rekey_flush", ks_level, 0);

    // Reset mid-message.
    ks_src = '{8'h01, 8'h02, 8'h03, 8'h04};
    pt_src = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    d0 = done_cnt;
    do_start(5);
    idle(3);
    do_reset();
    check_reset_values("midrst");
    idle(4);
    check("midrst_no_done", done_cnt - d0, 0);
`else
    // Drop-4: keystream 01..06, message "AB".
    ks_src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    pt_src = '{8'h41, 8'h42};
    base = ct_log.size();
    do_start(2);
    run_until_done("d1_done", 60);
    check("d1_ct0", ct_log[base], 8'h44);
    check("d1_ct1", ct_log[base+1], 8'h44);
    idle(1);
    rekey = 1'b1;
    idle(1);
    rekey = 1'b0;
    ks_src = '{8'h07, 8'h08, 8'h09, 8'h0a, 8'h0b, 8'h0c};
    pt_src = '{8'h41, 8'h42};
    base = ct_log.size();
    do_start(2);
    run_until_done("d2_done", 60);
    check("d2_ct0", ct_log[base], 8'h4a);
    check("d2_ct1", ct_log[base+1], 8'h4e);
    do_reset();
    check_reset_values("d_reset");
`endif

    // Randomized messages with random valid/ready pacing.
    for (int m = 0; m < 30; m++) begin
      ks_pct = $urandom_range(100, 30);
      pt_pct = $urandom_range(100, 30);
      ct_pct = $urandom_range(100, 30);
      if ($urandom_range(5) == 0 && ks_src.size() == 0) begin
        rekey = 1'b1;
        idle(1);
        rekey = 1'b0;
      end
      len  = $urandom_range(10);
      need = len - ks_m.size() - ks_src.size();
`ifdef RC4_DISCARD_EN
      if (pend_e && len != 0) need += DISCARD_N;
`endif
      if (need > 0) need += $urandom_range(2);
      for (int i = 0; i < need; i++) ks_src.push_back(8'($urandom_range(255)));
      for (int i = 0; i < len; i++) pt_src.push_back(8'($urandom_range(255)));
      do_start(len);
      run_until_done("rand_done", 400);
      idle($urandom_range(2));
    end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
